// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder used by the serial datapath.
// Ports: a, b, cin in; s (sum bit), cout (carry) out.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first.
// Ports: clk, rst_n; in_valid/in_ready with a, b; out_valid/out_ready
// with sum, carry_out.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           next;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             fa_s;
    logic             fa_cout;

    full_adder_bit u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next      = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    // The result register fills from the MSB end, so after WIDTH
    // shifts it holds the full sum with bit 0 in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            opa   <= a;
            opb   <= b;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            res   <= (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            carry <= fa_cout;
            cnt   <= cnt + CW'(1);
        end
    end

    assign sum       = res;
    assign carry_out = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8.
// Directed and random operands checked against plain a+b arithmetic.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    int checks;
    int errors;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, wait for the result, check it, retire it.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] ref_sum;
        int n;
        ref_sum = {1'b0, x} + {1'b0, y};
        chk("op_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("op_latency", 32'(n), 32'(W));
        chk("op_sum", 32'(sum), 32'(ref_sum[W-1:0]));
        chk("op_cout", 32'(carry_out), 32'(ref_sum[W]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("op_ret_valid", 32'(out_valid), 32'd0);
        chk("op_ret_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W:0] bp_ref;
        logic [W:0] exp_q[$];
        int acc_edge[$];
        int edge_no;
        int results;
        int accepts;
        int last_acc;
        logic rdy_before;
        logic vld_before;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(carry_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_op(8'h03, 8'h05);
        do_op(8'hFF, 8'h01);
        do_op(8'hFF, 8'hFF);
        do_op(8'h00, 8'h00);

        for (int i = 0; i < 6; i++) begin
            do_op(W'($urandom), W'($urandom));
        end

        // Backpressure with in_valid noise during RUN and DONE.
        bp_ref   = {1'b0, 8'h5A} + {1'b0, 8'h33};
        in_valid = 1'b1;
        a        = 8'h5A;
        b        = 8'h33;
        tick();
        a = 8'h11;
        b = 8'h11;
        for (int i = 0; i < W; i++) begin
            chk("bp_run_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("bp_done_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_sum", 32'(sum), 32'(bp_ref[W-1:0]));
            chk("bp_hold_cout", 32'(carry_out), 32'(bp_ref[W]));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_keep_sum", 32'(sum), 32'(bp_ref[W-1:0]));
        chk("bp_keep_cout", 32'(carry_out), 32'(bp_ref[W]));

        // Reset in the middle of a run.
        in_valid = 1'b1;
        a        = 8'h3C;
        b        = 8'hF0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_run_ready", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(carry_out), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mid_no_result", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h10, 8'h20);

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = W'($urandom);
        b         = W'($urandom);
        edge_no   = 0;
        results   = 0;
        accepts   = 0;
        last_acc  = 0;
        while (results < 3 && edge_no < 200) begin
            rdy_before = in_ready;
            vld_before = out_valid;
            if (rdy_before && in_valid) begin
                exp_q.push_back({1'b0, a} + {1'b0, b});
                acc_edge.push_back(edge_no);
            end
            tick();
            if (rdy_before && in_valid) begin
                if (accepts > 0) begin
                    chk("b2b_spacing", 32'(edge_no - last_acc),
                        32'(W + 2));
                end
                last_acc = edge_no;
                accepts++;
                a = W'($urandom);
                b = W'($urandom);
                if (accepts == 3) begin
                    in_valid = 1'b0;
                end
            end
            edge_no++;
            if (out_valid && !vld_before) begin
                if (exp_q.size() > 0) begin
                    logic [W:0] e;
                    int ae;
                    e  = exp_q.pop_front();
                    ae = acc_edge.pop_front();
                    chk("b2b_latency", 32'(edge_no - 1 - ae), 32'(W));
                    chk("b2b_sum", 32'(sum), 32'(e[W-1:0]));
                    chk("b2b_cout", 32'(carry_out), 32'(e[W]));
                end else begin
                    chk("b2b_unexpected", 32'd1, 32'd0);
                end
                results++;
            end
        end
        chk("b2b_results", 32'(results), 32'd3);
        tick();
        chk("b2b_final_idle", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operands a and b are presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-007 SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-008 SHALL have port out_valid, output, 1 bit: sum and carry_out hold a result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port sum, output, WIDTH bits: (a+b) mod 2^WIDTH.
REQ-011 SHALL have port carry_out, output, 1 bit: bit WIDTH of a+b.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 IDLE SHALL drive in_ready=1 and out_valid=0.
REQ-014 In IDLE, on in_valid=1 at a rising edge, the block SHALL capture a and b into shift registers, clear the carry flop and the bit counter, and enter RUN.
REQ-015 RUN SHALL process one bit per cycle, LSB first, from the current LSBs and the carry flop through a 1-bit full adder.
- The sum bit shifts into the result register from the MSB end.
- The carry flop takes the carry out of that bit.
- Both operand registers shift right by one.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1 the FSM SHALL enter DONE.
- out_valid therefore rises WIDTH edges after the accept edge.
REQ-017 DONE SHALL drive out_valid=1 and present sum and carry_out from registers.
- sum and carry_out SHALL hold stable while out_ready=0, for any number of cycles.
REQ-018 In DONE, on out_ready=1 at an edge, the FSM SHALL return to IDLE.
- sum and carry_out SHALL keep their values until the next accept.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored there, with no capture or queuing.
REQ-020 There SHALL be no same-cycle bypass: after a DONE->IDLE edge, the next accept is possible no earlier than the following edge.
REQ-021 The bit counter SHALL be sized ceil(log2(WIDTH))+1 bits and SHALL NOT wrap during a run.
REQ-022 With WIDTH=1, RUN SHALL last one cycle.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE and clear to 0: operand registers, result, carry flop, counter, sum, carry_out and out_valid.
REQ-024 in_ready SHALL read 1 while reset is asserted.
REQ-025 Reset asserted mid-RUN or in DONE SHALL discard the operation; no result is ever presented for it.
REQ-026 On rst_n deassertion, the first accept SHALL be possible on the first rising edge.

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold:
- the state enum typedef (IDLE, RUN, DONE);
- the default-width constant (8).
REQ-028 The bit arithmetic SHALL live in one combinational sub-module, full_adder_bit (inputs a, b, cin; outputs s, cout), instantiated once.
REQ-029 All other logic (FSM, shift registers, counter) SHALL be in serial_adder; no other sub-modules.

Verification
REQ-030 The bench SHALL cover, at WIDTH=8:
- Basic add: a=0x03, b=0x05 accepted at edge E0 -> out_valid high after E8, sum=0x08, carry_out=0.
- Carry wrap: a=0xFF, b=0x01 -> sum=0x00, carry_out=1.
- Maximum: a=0xFF, b=0xFF -> sum=0xFE, carry_out=1.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> sum, carry_out and out_valid stable. During RUN and DONE, in_valid=1 with a=0x11 -> in_ready=0 and no capture. Then out_ready=1 -> IDLE on that edge.
- Reset mid-run: rst_n=0 at RUN bit 4 -> same-cycle out_valid=0, sum=0, carry_out=0, in_ready=1. After release, a=0x10, b=0x20 -> sum=0x30.
- Back-to-back: in_valid held high with out_ready=1 over 3 operand pairs -> each result appears WIDTH edges after its accept, and there are WIDTH+2 edges between consecutive accepts.
